adder4_sched: RTL and testbench
===============================

# adder4_sched

Sequencer and arbiter for a single shared 4-bit ripple-carry adder. Two requesters each submit W-bit operand pairs (W = 4·NIBBLES). The block grants one requester round-robin, then drives the shared adder one nibble per cycle, least-significant first, chaining the carry through a register. It returns a (W+1)-bit sum tagged with the requester ID. It sits between the tile's operand sources and the adder instance, which stays purely combinational and external to this block.

## Interface

- NIBBLES, 2, operand width in nibbles; legal range 1..4; W = 4·NIBBLES
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b  as for requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_sum  out  W+1  a+b; MSB is the final carry
- fa_a, fa_b  out  4  nibble operands to the shared adder
- fa_cin  out  1  carry-in to the shared adder
- fa_sum  in  4  adder sum nibble
- fa_cout  in  1  adder carry-out
- busy  out  1  high whenever state ≠ IDLE

## Operation

- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - If neither valid is high: stay.
  - If exactly one valid is high: grant that requester.
  - If both valid are high: grant the requester ≠ last_grant.
  - Grant means the granted reqX_ready is high combinationally in the same cycle. The other ready is low.
  - On the edge: latch the a/b operands and the ID, update last_grant, set k=0, carry=0, go to RUN.
- reqX_ready is never high outside IDLE.
- **RUN** (nibble index k = 0..NIBBLES-1)
  - fa_a = A[4k+3:4k], fa_b = B[4k+3:4k].
  - fa_cin = 0 when k=0, otherwise the carry register.
  - On the edge: sum[4k+3:4k] ← fa_sum, carry ← fa_cout, k ← k+1.
  - After nibble NIBBLES-1: sum[W] ← fa_cout, go to RESP.
- **RESP**
  - rsp_valid high.
  - rsp_sum and rsp_id are stable until the handshake.
  - On rsp_valid&rsp_ready: go to IDLE.
- Outside RUN, fa_a, fa_b and fa_cin are driven to 0.
- Arithmetic is unsigned with no truncation. The W+1 result width holds the maximum sum.
- The operand registers are loaded only on the accept handshake. A requester may change its inputs freely after its ready pulse.
- Reset (asynchronous, any state, including mid-RUN or RESP):
  - state=IDLE, k=0, carry=0, sum=0, id=0.
  - last_grant=1, so requester 0 wins the first contention.
  - The in-flight operation is discarded and no response is produced.

## Timing

- Reset values: req0_ready/req1_ready follow the IDLE rule (no valid → 0), rsp_valid=0, rsp_id=0, rsp_sum=0, fa_a=fa_b=0, fa_cin=0, busy=0.
- Accept at edge E0. RUN occupies cycles E0+1 .. E0+NIBBLES. rsp_valid rises in cycle E0+NIBBLES+1.
- Latency is NIBBLES+1 cycles from accept to rsp_valid.
- With rsp_ready held high, rsp_valid is high for exactly 1 cycle. The next accept can occur in the cycle after that, giving a minimum issue interval of NIBBLES+2 cycles.
- Backpressure: RESP holds indefinitely while rsp_ready=0. No new request is accepted during this time.
- rsp_ready asserted outside RESP is ignored.
- A valid that drops before being granted is simply not serviced. No ready is generated for it.
- The fa_* path is combinational through the external adder. It is registered only inside this block.

## Test plan

- **Basic add (NIBBLES=2):** req0 0x3C+0x5A → rsp_sum=0x096, rsp_id=0. rsp_valid occurs 3 cycles after accept. fa_cin=0 on nibble 0, and carry=1 is applied on nibble 1.
- **Full carry chain:** req1 0xFF+0x01 → rsp_sum=0x100, rsp_id=1. Also 0xFF+0xFF → 0x1FE.
- **Contention / fairness:** req0 and req1 both held valid after reset. Grants alternate 0,1,0,1 over 4 operations. Each result carries the correct rsp_id and sum, e.g. req0 0x10+0x20 → 0x030 and req1 0x80+0x80 → 0x100.
- **Backpressure:** rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_sum and rsp_id stay stable, and req ready stays low. Raising rsp_ready gives IDLE on the next cycle.
- **Reset mid-RUN:** assert rst while k=1. Outputs return to their reset values immediately (asynchronously), and no rsp_valid ever appears for that operation. The next contention grants req0.
- **NIBBLES=1 build:** 0xF+0xF → rsp_sum=0x1E. rsp_valid is 2 cycles after accept, and fa_cin is 0 throughout.

Source files
------------

// File: rtl/adder4_sched.sv
// adder4_sched: round-robin front end for one shared external 4-bit adder.
// Two requesters submit W-bit operand pairs. The granted pair is added one
// nibble per cycle, least-significant nibble first, with the carry held in
// a register between nibbles. The (W+1)-bit result is returned with the
// owner's ID.
module adder4_sched #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES:0]   rsp_sum,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout,
  output logic                 busy
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] K_LAST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic [2:0]     k;
  logic           carry_p1;
  logic [W:0]     sum_p1;
  logic           id_p0;
  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;

  // Select nibble idx (idx 0 = least significant) of a W-bit word.
  function automatic logic [3:0] nibble_of(input logic [W-1:0] word,
                                           input logic [2:0]   idx);
    logic [W-1:0] shifted;
    shifted = word >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

  // Round-robin arbitration: a lone valid wins, contention goes to the
  // requester that was not granted last time.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign accept = (state == IDLE) & (grant0 | grant1);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake / adder-drive outputs.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fa_a       = 4'd0;
    fa_b       = 4'd0;
    fa_cin     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        fa_a   = nibble_of(a_p0, k);
        fa_b   = nibble_of(b_p0, k);
        // The lowest nibble never takes a carry-in.
        fa_cin = (k == 3'd0) ? 1'b0 : carry_p1;
        if (k == K_LAST) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p0: operand capture on the accept handshake ----
  // Operands need no reset: they are only read after an accept reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= grant1 ? req1_a : req0_a;
      b_p0 <= grant1 ? req1_b : req0_b;
    end
  end

  // ---- stage p1: nibble sequencing, carry chain and result assembly ----
  // Every nibble of sum_p1 plus its MSB is rewritten by each operation, so
  // it is not cleared on accept; a reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k          <= 3'd0;
      carry_p1   <= 1'b0;
      sum_p1     <= '0;
      id_p0      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      id_p0      <= grant1;
      last_grant <= grant1;
      k          <= 3'd0;
      carry_p1   <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (k == 3'(i)) begin
          sum_p1[4*i +: 4] <= fa_sum;
        end
      end
      if (k == K_LAST) begin
        sum_p1[W] <= fa_cout;
      end
      carry_p1 <= fa_cout;
      k        <= k + 3'd1;
    end
  end

  assign rsp_sum = sum_p1;
  assign rsp_id  = id_p0;

endmodule

// File: tb/tb_adder4_sched.sv
// Bench for adder4_sched: a transaction-level model predicts grants,
// nibble traffic to the adder and results; one per-cycle compare routine
// checks the DUT against it. A second NIBBLES=1 instance covers the
// single-nibble build.
module tb_adder4_sched;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         v0, v1, rr;
  logic [W-1:0] a0, b0, a1, b1;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [W:0]   rsp_sum;
  logic [3:0]   fa_a, fa_b, fa_sum;
  logic         fa_cin, fa_cout;

  logic         n_v0, n_v1, n_rr;
  logic [3:0]   n_a0, n_b0, n_a1, n_b1;
  logic         n_req0_ready, n_req1_ready, n_rsp_valid, n_rsp_id, n_busy;
  logic [4:0]   n_rsp_sum;
  logic [3:0]   n_fa_a, n_fa_b, n_fa_sum;
  logic         n_fa_cin, n_fa_cout;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 idle, 1 adding nibble m_j, 2 holding the result.
  int m_phase, m_j, m_a, m_b, m_id, m_last;
  logic [31:0] obs_sum[$];
  logic [31:0] obs_id[$];

  adder4_sched #(.NIBBLES(N)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum),
    .fa_cout(fa_cout), .busy(busy)
  );

  adder4_sched #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(n_v0), .req0_ready(n_req0_ready), .req0_a(n_a0), .req0_b(n_b0),
    .req1_valid(n_v1), .req1_ready(n_req1_ready), .req1_a(n_a1), .req1_b(n_b1),
    .rsp_valid(n_rsp_valid), .rsp_ready(n_rr), .rsp_id(n_rsp_id),
    .rsp_sum(n_rsp_sum), .fa_a(n_fa_a), .fa_b(n_fa_b), .fa_cin(n_fa_cin),
    .fa_sum(n_fa_sum), .fa_cout(n_fa_cout), .busy(n_busy)
  );

  // External shared adders (purely combinational).
  assign {fa_cout, fa_sum}     = 5'(fa_a) + 5'(fa_b) + 5'(fa_cin);
  assign {n_fa_cout, n_fa_sum} = 5'(n_fa_a) + 5'(n_fa_b) + 5'(n_fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_j = 0; m_last = 1; m_id = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, and
  // return 1 time unit after the next rising edge.
  task automatic cycle();
    int g0, g1, ea, eb, ec, mask;
    @(negedge clk);
    g0 = 0; g1 = 0; ea = 0; eb = 0; ec = 0;
    if (m_phase == 0) begin
      g0 = (v0 && (!v1 || m_last == 1)) ? 1 : 0;
      g1 = (v1 && (!v0 || m_last == 0)) ? 1 : 0;
    end
    if (m_phase == 1) begin
      ea   = (m_a >> (4 * m_j)) & 15;
      eb   = (m_b >> (4 * m_j)) & 15;
      mask = (1 << (4 * m_j)) - 1;
      ec   = ((m_a & mask) + (m_b & mask)) >> (4 * m_j);
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
    chk("fa_a", fa_a, ea);
    chk("fa_b", fa_b, eb);
    chk("fa_cin", fa_cin, ec);
    if (m_phase == 2) begin
      chk("rsp_sum", rsp_sum, m_a + m_b);
      chk("rsp_id", rsp_id, m_id);
    end
    if (rsp_valid && rr) begin
      obs_sum.push_back(32'(rsp_sum));
      obs_id.push_back(32'(rsp_id));
    end
    case (m_phase)
      0: if (g0 || g1) begin
        m_id = g1; m_last = g1;
        m_a = g1 ? int'(a1) : int'(a0);
        m_b = g1 ? int'(b1) : int'(b0);
        m_phase = 1; m_j = 0;
      end
      1: begin
        m_j++;
        if (m_j == N) m_phase = 2;
      end
      default: if (rr) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; n_v0 = 0; n_v1 = 0;
    rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_fa_a", fa_a, 0);
    chk("rst_fa_b", fa_b, 0);
    chk("rst_fa_cin", fa_cin, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_n_busy", n_busy, 0);
    chk("rst_n_rsp_valid", n_rsp_valid, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  // Single request from one requester with a literal expected result.
  task automatic op_lit(input string nm, input int sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W:0] exp_sum);
    obs_sum.delete(); obs_id.delete();
    if (sel == 1) begin v1 = 1; a1 = a; b1 = b; end
    else begin v0 = 1; a0 = a; b0 = b; end
    cycle();
    v0 = 0; v1 = 0;
    for (int i = 0; i < 20 && obs_sum.size() == 0; i++) cycle();
    chk({nm, "_count"}, obs_sum.size(), 1);
    if (obs_sum.size() > 0) begin
      chk({nm, "_sum"}, obs_sum[0], 32'(exp_sum));
      chk({nm, "_id"}, obs_id[0], sel);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; rr = 1; v0 = 0; v1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    n_v0 = 0; n_v1 = 0; n_rr = 1;
    n_a0 = 0; n_b0 = 0; n_a1 = 0; n_b1 = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic add with nibble-level visibility of the carry chain.
    v0 = 1; a0 = 8'h3C; b0 = 8'h5A; rr = 1;
    cycle();
    v0 = 0;
    chk("basic_fa_a0", fa_a, 4'hC);
    chk("basic_fa_b0", fa_b, 4'hA);
    chk("basic_fa_cin0", fa_cin, 0);
    chk("basic_busy", busy, 1);
    cycle();
    chk("basic_fa_a1", fa_a, 4'h3);
    chk("basic_fa_b1", fa_b, 4'h5);
    chk("basic_fa_cin1", fa_cin, 1);
    cycle();
    chk("basic_rsp_valid", rsp_valid, 1);
    chk("basic_rsp_sum", rsp_sum, 9'h096);
    chk("basic_rsp_id", rsp_id, 0);
    cycle();

    // Full carry chains.
    op_lit("ff_01", 1, 8'hFF, 8'h01, 9'h100);
    op_lit("ff_ff", 0, 8'hFF, 8'hFF, 9'h1FE);
    drain(1);

    // Contention straight after reset: grants alternate starting with req0.
    do_reset();
    obs_sum.delete(); obs_id.delete();
    v0 = 1; a0 = 8'h10; b0 = 8'h20;
    v1 = 1; a1 = 8'h80; b1 = 8'h80;
    for (int i = 0; i < 40 && obs_id.size() < 4; i++) cycle();
    v0 = 0; v1 = 0;
    chk("fair_count", obs_id.size(), 4);
    for (int i = 0; i < obs_id.size(); i++) begin
      chk("fair_id", obs_id[i], i % 2);
      chk("fair_sum", obs_sum[i], (i % 2) ? 32'h100 : 32'h030);
    end
    drain(2);

    // Backpressure: result held, other requester kept waiting.
    rr = 0; v0 = 1; a0 = 8'h81; b0 = 8'h92;
    cycle();
    v0 = 0; v1 = 1; a1 = 8'h44; b1 = 8'h55;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_sum", rsp_sum, 9'h113);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_req1_ready", req1_ready, 0);
      cycle();
    end
    rr = 1;
    cycle();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_req1_ready", req1_ready, 1);
    cycle();
    v1 = 0;
    drain(4);

    // Reset in the middle of RUN (k = 1): operation discarded.
    v0 = 1; a0 = 8'h77; b0 = 8'h11;
    cycle();
    v0 = 0;
    cycle();
    chk("mid_busy_before", busy, 1);
    obs_sum.delete(); obs_id.delete();
    do_reset();
    drain(6);
    chk("mid_no_rsp", obs_sum.size(), 0);
    v0 = 1; a0 = 8'h01; b0 = 8'h02;
    v1 = 1; a1 = 8'h03; b1 = 8'h04;
    #1;
    chk("mid_grant0", req0_ready, 1);
    chk("mid_grant1", req1_ready, 0);
    cycle();
    v0 = 0; v1 = 0;
    drain(4);

    // Randomized traffic with random backpressure and drop-outs.
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      b0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      b1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cycle();
    end
    v0 = 0; v1 = 0; rr = 1;
    drain(5);

    // Single-nibble build.
    n_rr = 1; n_v0 = 1; n_a0 = 4'hF; n_b0 = 4'hF;
    #1;
    chk("n1_ready", n_req0_ready, 1);
    @(posedge clk);
    #1;
    n_v0 = 0;
    chk("n1_busy", n_busy, 1);
    chk("n1_fa_a", n_fa_a, 4'hF);
    chk("n1_fa_b", n_fa_b, 4'hF);
    chk("n1_fa_cin", n_fa_cin, 0);
    chk("n1_rsp_early", n_rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("n1_rsp_valid", n_rsp_valid, 1);
    chk("n1_rsp_sum", n_rsp_sum, 5'h1E);
    chk("n1_rsp_id", n_rsp_id, 0);
    chk("n1_fa_cin_resp", n_fa_cin, 0);
    @(posedge clk);
    #1;
    chk("n1_idle_busy", n_busy, 0);
    chk("n1_idle_rsp_valid", n_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
